// File: rtl/sdram_port_arbiter.sv
// Burst sequencer/arbiter sharing one SDRAM controller between TFT reads, UART writes and auto-refresh.
// Define ARB_STARVE_GUARD_EN to let a starved write outrank reads after STARVE_MAX read grants.
module sdram_port_arbiter #(
  parameter int ADDR_W     = 22,
  parameter int REF_PERIOD = 390,
  parameter int STARVE_MAX = 4
) (
  input  logic              sys_clk,
  input  logic              sys_nrst,
  input  logic              rd_req,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic              rd_gnt,
  output logic              rd_done,
  input  logic              wr_req,
  input  logic [ADDR_W-1:0] wr_addr,
  output logic              wr_gnt,
  output logic              wr_done,
  output logic              ctl_valid,
  output logic [1:0]        ctl_cmd,
  output logic [ADDR_W-1:0] ctl_addr,
  input  logic              ctl_ready,
  input  logic              ctl_done,
  output logic [1:0]        owner,
  output logic              ref_miss
);

  localparam int TMR_W = $clog2(REF_PERIOD);
  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(REF_PERIOD - 1);

  localparam logic [1:0] CMD_NONE = 2'd0;
  localparam logic [1:0] CMD_RD   = 2'd1;
  localparam logic [1:0] CMD_WR   = 2'd2;
  localparam logic [1:0] CMD_REF  = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_BUSY  = 2'd2
  } state_t;

  state_t            state_reg, state_next;
  logic [1:0]        cmd_reg, cmd_next;
  logic [ADDR_W-1:0] addr_reg, addr_next;

  logic [TMR_W-1:0]  timer_reg;
  logic              ref_pending_reg;
  logic              ref_miss_reg;
  logic              rd_gnt_reg, wr_gnt_reg, rd_done_reg, wr_done_reg;

  logic handshake, burst_end, timer_wrap, ref_hs, wr_boost;

  assign handshake  = (state_reg == ST_ISSUE) && ctl_ready;
  assign burst_end  = (state_reg == ST_BUSY) && ctl_done;
  assign timer_wrap = (timer_reg == TMR_LAST);
  assign ref_hs     = handshake && (cmd_reg == CMD_REF);

`ifdef ARB_STARVE_GUARD_EN
  localparam int STARVE_W = $clog2(STARVE_MAX + 1);
  localparam logic [STARVE_W-1:0] STARVE_LIM = STARVE_W'(STARVE_MAX);

  logic [STARVE_W-1:0] starve_reg;

  // Saturates so a write that appears mid-grant cannot push the count past the trip point.
  always_ff @(posedge sys_clk) begin
    if (!sys_nrst) begin
      starve_reg <= '0;
    end else if (wr_gnt_reg) begin
      starve_reg <= '0;
    end else if (rd_gnt_reg && wr_req && (starve_reg != STARVE_LIM)) begin
      starve_reg <= starve_reg + 1'b1;
    end
  end

  assign wr_boost = wr_req && (starve_reg == STARVE_LIM);
`else
  assign wr_boost = 1'b0;
`endif

  // State register, including the latched command of the current burst.
  always_ff @(posedge sys_clk) begin
    if (!sys_nrst) begin
      state_reg <= ST_IDLE;
      cmd_reg   <= CMD_NONE;
      addr_reg  <= '0;
    end else begin
      state_reg <= state_next;
      cmd_reg   <= cmd_next;
      addr_reg  <= addr_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    cmd_next   = cmd_reg;
    addr_next  = addr_reg;
    unique case (state_reg)
      ST_IDLE: begin
        if (ref_pending_reg) begin
          state_next = ST_ISSUE;
          cmd_next   = CMD_REF;
          addr_next  = '0;
        end else if (wr_boost) begin
          state_next = ST_ISSUE;
          cmd_next   = CMD_WR;
          addr_next  = wr_addr;
        end else if (rd_req) begin
          state_next = ST_ISSUE;
          cmd_next   = CMD_RD;
          addr_next  = rd_addr;
        end else if (wr_req) begin
          state_next = ST_ISSUE;
          cmd_next   = CMD_WR;
          addr_next  = wr_addr;
        end
      end
      ST_ISSUE: if (ctl_ready) state_next = ST_BUSY;
      ST_BUSY:  if (ctl_done)  state_next = ST_IDLE;
      default:  state_next = ST_IDLE;
    endcase
  end

  always_comb begin
    ctl_valid = 1'b0;
    ctl_cmd   = CMD_NONE;
    ctl_addr  = '0;
    owner     = CMD_NONE;
    if (state_reg == ST_ISSUE) begin
      ctl_valid = 1'b1;
      ctl_cmd   = cmd_reg;
      ctl_addr  = addr_reg;
    end
    if (state_reg != ST_IDLE) owner = cmd_reg;
  end

  // A refresh wrap coinciding with its own handshake re-arms the request rather than missing it.
  always_ff @(posedge sys_clk) begin
    if (!sys_nrst) begin
      timer_reg       <= '0;
      ref_pending_reg <= 1'b0;
      ref_miss_reg    <= 1'b0;
    end else begin
      timer_reg <= timer_wrap ? '0 : timer_reg + 1'b1;
      if (timer_wrap) begin
        ref_pending_reg <= 1'b1;
      end else if (ref_hs) begin
        ref_pending_reg <= 1'b0;
      end
      if (timer_wrap && ref_pending_reg && !ref_hs) ref_miss_reg <= 1'b1;
    end
  end

  always_ff @(posedge sys_clk) begin
    if (!sys_nrst) begin
      rd_gnt_reg  <= 1'b0;
      wr_gnt_reg  <= 1'b0;
      rd_done_reg <= 1'b0;
      wr_done_reg <= 1'b0;
    end else begin
      rd_gnt_reg  <= handshake && (cmd_reg == CMD_RD);
      wr_gnt_reg  <= handshake && (cmd_reg == CMD_WR);
      rd_done_reg <= burst_end && (cmd_reg == CMD_RD);
      wr_done_reg <= burst_end && (cmd_reg == CMD_WR);
    end
  end

  assign rd_gnt   = rd_gnt_reg;
  assign wr_gnt   = wr_gnt_reg;
  assign rd_done  = rd_done_reg;
  assign wr_done  = wr_done_reg;
  assign ref_miss = ref_miss_reg;

endmodule

// File: tb/tb_sdram_port_arbiter.sv
// Directed bench for sdram_port_arbiter: cycle-level reference model plus literal scenario checks.
// Honours ARB_STARVE_GUARD_EN for the starvation scenario.
module tb_sdram_port_arbiter;

  localparam int ADDR_W     = 22;
  localparam int REF_PERIOD = 390;
  localparam int STARVE_MAX = 4;

  logic              sys_clk = 1'b0;
  logic              sys_nrst = 1'b0;
  logic              rd_req = 1'b0, wr_req = 1'b0;
  logic [ADDR_W-1:0] rd_addr = '0, wr_addr = '0;
  logic              ctl_ready = 1'b1;
  logic              ctl_done = 1'b0;
  logic              rd_gnt, rd_done, wr_gnt, wr_done, ctl_valid, ref_miss;
  logic [1:0]        ctl_cmd, owner;
  logic [ADDR_W-1:0] ctl_addr;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int done_at = -1;
  bit auto_drop = 1'b1;

  sdram_port_arbiter #(.ADDR_W(ADDR_W), .REF_PERIOD(REF_PERIOD), .STARVE_MAX(STARVE_MAX)) dut (
    .sys_clk(sys_clk), .sys_nrst(sys_nrst),
    .rd_req(rd_req), .rd_addr(rd_addr), .rd_gnt(rd_gnt), .rd_done(rd_done),
    .wr_req(wr_req), .wr_addr(wr_addr), .wr_gnt(wr_gnt), .wr_done(wr_done),
    .ctl_valid(ctl_valid), .ctl_cmd(ctl_cmd), .ctl_addr(ctl_addr),
    .ctl_ready(ctl_ready), .ctl_done(ctl_done), .owner(owner), .ref_miss(ref_miss)
  );

  always #5 sys_clk = ~sys_clk;

  // Cycle index: 0 in the cycle after the last reset edge.
  always @(posedge sys_clk) cyc <= sys_nrst ? cyc + 1 : 0;

  // Controller emulator: completes every accepted command 3 cycles after its handshake.
  always @(posedge sys_clk) begin
    if (!sys_nrst) done_at <= -1;
    else if (ctl_valid && ctl_ready) done_at <= cyc + 3;
  end
  always @(negedge sys_clk) ctl_done <= (cyc == done_at);

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cyc %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------- reference model ----------------
  int         m_age = 0, m_ph = 0, m_starve = 0;
  logic [1:0] m_cmd = 2'd0;
  logic [ADDR_W-1:0] m_addr = '0;
  logic m_pend = 0, m_miss = 0, m_rg = 0, m_wg = 0, m_rd = 0, m_wd = 0;
  wire  m_wrap = (((m_age + 1) % REF_PERIOD) == 0);
  wire  m_hs   = (m_ph == 1) && ctl_ready;

  function automatic logic [1:0] m_pick();
    if (m_pend) return 2'd3;
`ifdef ARB_STARVE_GUARD_EN
    if (wr_req && m_starve == STARVE_MAX) return 2'd2;
`endif
    if (rd_req) return 2'd1;
    if (wr_req) return 2'd2;
    return 2'd0;
  endfunction

  always @(posedge sys_clk) begin
    if (!sys_nrst) begin
      m_age <= 0; m_ph <= 0; m_starve <= 0; m_cmd <= 2'd0; m_addr <= '0;
      m_pend <= 0; m_miss <= 0; m_rg <= 0; m_wg <= 0; m_rd <= 0; m_wd <= 0;
    end else begin
      m_age <= m_age + 1;
      m_rg <= m_hs && m_cmd == 2'd1;
      m_wg <= m_hs && m_cmd == 2'd2;
      m_rd <= (m_ph == 2) && ctl_done && m_cmd == 2'd1;
      m_wd <= (m_ph == 2) && ctl_done && m_cmd == 2'd2;
      if (m_ph == 0 && m_pick() != 2'd0) begin
        m_ph   <= 1;
        m_cmd  <= m_pick();
        m_addr <= (m_pick() == 2'd1) ? rd_addr : (m_pick() == 2'd2) ? wr_addr : '0;
      end else if (m_ph == 1 && ctl_ready) m_ph <= 2;
      else if (m_ph == 2 && ctl_done) m_ph <= 0;
      if (m_wrap) begin
        m_pend <= 1;
        if (m_pend && !(m_hs && m_cmd == 2'd3)) m_miss <= 1;
      end else if (m_hs && m_cmd == 2'd3) m_pend <= 0;
      if (m_wg) m_starve <= 0;
      else if (m_rg && wr_req && m_starve < STARVE_MAX) m_starve <= m_starve + 1;
    end
  end

  always @(negedge sys_clk) begin
    chk("ctl_valid", 32'(ctl_valid), 32'(m_ph == 1));
    chk("ctl_cmd",   32'(ctl_cmd),   (m_ph == 1) ? 32'(m_cmd) : 32'd0);
    chk("ctl_addr",  32'(ctl_addr),  (m_ph == 1) ? 32'(m_addr) : 32'd0);
    chk("owner",     32'(owner),     (m_ph != 0) ? 32'(m_cmd) : 32'd0);
    chk("rd_gnt",    32'(rd_gnt),    32'(m_rg));
    chk("wr_gnt",    32'(wr_gnt),    32'(m_wg));
    chk("rd_done",   32'(rd_done),   32'(m_rd));
    chk("wr_done",   32'(wr_done),   32'(m_wd));
    chk("ref_miss",  32'(ref_miss),  32'(m_miss));
  end

  // ---------------- event log ----------------
  typedef struct { int cyc; int kind; int cmd; int addr; } ev_t;
  ev_t log_q[$];
  int  log_base = 0;
  logic pv = 1'b0, pm = 1'b0;

  always @(negedge sys_clk) begin
    if (ctl_valid && !pv) begin
      log_q.push_back('{cyc, 1, int'(ctl_cmd), int'(ctl_addr)});
      $display("txn cyc=%0d cmd=%0d addr=0x%06h", cyc, ctl_cmd, ctl_addr);
    end
    if (rd_gnt)  log_q.push_back('{cyc, 2, 1, 0});
    if (wr_gnt)  log_q.push_back('{cyc, 3, 2, 0});
    if (rd_done) log_q.push_back('{cyc, 4, 1, 0});
    if (wr_done) log_q.push_back('{cyc, 5, 2, 0});
    if (ref_miss && !pm) log_q.push_back('{cyc, 6, 0, 0});
    pv <= ctl_valid;
    pm <= ref_miss;
  end

  function automatic int find_ev(input int kind, input int nth);
    int n = 0;
    for (int i = log_base; i < log_q.size(); i++)
      if (log_q[i].kind == kind) begin
        if (n == nth) return i;
        n++;
      end
    return -1;
  endfunction

  function automatic int ev_cyc(input int idx);
    return (idx < 0) ? -1 : log_q[idx].cyc;
  endfunction

  function automatic int count_ev(input int kind, input int max_cyc);
    int n = 0;
    for (int i = log_base; i < log_q.size(); i++)
      if (log_q[i].kind == kind && log_q[i].cyc <= max_cyc) n++;
    return n;
  endfunction

  // ---------------- stimulus ----------------
  task automatic step(input int n);
    repeat (n) begin
      @(negedge sys_clk);
      if (auto_drop && rd_gnt) rd_req = 1'b0;
      if (auto_drop && wr_gnt) wr_req = 1'b0;
    end
  endtask

  task automatic do_reset();
    sys_nrst = 1'b0; rd_req = 1'b0; wr_req = 1'b0; rd_addr = '0; wr_addr = '0;
    ctl_ready = 1'b1; auto_drop = 1'b1;
    step(3);
    sys_nrst = 1'b1;
    log_base = log_q.size();
  endtask

  initial begin
    int i0, i1, n;
    int seq[10];
    int pat[10];

    // Reset state and refresh cadence with no requests.
    do_reset();
    chk("reset_valid", 32'(ctl_valid), 32'd0);
    chk("reset_owner", 32'(owner), 32'd0);
    chk("reset_miss", 32'(ref_miss), 32'd0);
    step(790);
    i0 = find_ev(1, 0); i1 = find_ev(1, 1);
    chk("ref1_cycle", ev_cyc(i0), 391);
    chk("ref1_cmd", (i0 < 0) ? 32'hFFFF : log_q[i0].cmd, 3);
    chk("ref2_cycle", ev_cyc(i1), 781);
    chk("ref_no_miss", 32'(ref_miss), 32'd0);

    // Simultaneous read and write: read first, write at ctl_done+2.
    do_reset();
    rd_req = 1'b1; rd_addr = 22'h000A2C;
    wr_req = 1'b1; wr_addr = 22'h001F00;
    step(15);
    i0 = find_ev(1, 0); i1 = find_ev(1, 1);
    chk("rw_rd_issue", ev_cyc(i0), 1);
    chk("rw_rd_addr", (i0 < 0) ? 32'hFFFF : log_q[i0].addr, 32'h000A2C);
    chk("rw_rd_gnt", ev_cyc(find_ev(2, 0)), 2);
    chk("rw_rd_done", ev_cyc(find_ev(4, 0)), 5);
    chk("rw_wr_issue", ev_cyc(i1), 6);
    chk("rw_wr_cmd", (i1 < 0) ? 32'hFFFF : log_q[i1].cmd, 2);
    chk("rw_wr_addr", (i1 < 0) ? 32'hFFFF : log_q[i1].addr, 32'h001F00);
    chk("rw_wr_gnt", ev_cyc(find_ev(3, 0)), 7);
    chk("rw_wr_done", ev_cyc(find_ev(5, 0)), 10);

    // Write held in ISSUE by ctl_ready low for 10 cycles.
    do_reset();
    ctl_ready = 1'b0;
    wr_req = 1'b1; wr_addr = 22'h2ABCDE;
    for (int k = 1; k <= 10; k++) begin
      step(1);
      chk("stall_valid", 32'(ctl_valid), 32'd1);
      chk("stall_addr", 32'(ctl_addr), 32'h2ABCDE);
      chk("stall_no_gnt", 32'(wr_gnt), 32'd0);
    end
    ctl_ready = 1'b1;
    step(1);
    chk("stall_gnt", 32'(wr_gnt), 32'd1);
    step(1);
    chk("stall_gnt_width", 32'(wr_gnt), 32'd0);
    step(8);

    // Both requests held high permanently.
    do_reset();
    auto_drop = 1'b0;
    rd_req = 1'b1; rd_addr = 22'h000100;
    wr_req = 1'b1; wr_addr = 22'h000200;
    step(122);
    n = count_ev(2, 120) + count_ev(3, 120);
    chk("hold_total_gnts", n, 24);
`ifdef ARB_STARVE_GUARD_EN
    pat = '{1, 1, 1, 1, 2, 1, 1, 1, 1, 2};
    n = 0;
    for (int i = log_base; i < log_q.size() && n < 10; i++)
      if (log_q[i].kind == 2 || log_q[i].kind == 3) begin
        seq[n] = log_q[i].cmd;
        n++;
      end
    for (int k = 0; k < 10; k++) chk("starve_pattern", seq[k], pat[k]);
`else
    seq[0] = count_ev(3, 120);
    pat[0] = 0;
    chk("strict_no_wr_gnt", seq[0], pat[0]);
    chk("strict_rd_gnts", count_ev(2, 120), 24);
`endif

    // Controller never ready: second interval expires with refresh still pending.
    do_reset();
    ctl_ready = 1'b0;
    step(800);
    chk("miss_cycle", ev_cyc(find_ev(6, 0)), 780);
    chk("miss_sticky", 32'(ref_miss), 32'd1);
    do_reset();
    chk("miss_cleared", 32'(ref_miss), 32'd0);

    // Reset during BUSY of a read, rd_req kept high.
    ctl_ready = 1'b1;
    auto_drop = 1'b0;
    rd_req = 1'b1; rd_addr = 22'h123456;
    step(3);
    chk("mid_owner_busy", 32'(owner), 32'd1);
    sys_nrst = 1'b0;
    step(1);
    chk("mid_valid", 32'(ctl_valid), 32'd0);
    chk("mid_owner", 32'(owner), 32'd0);
    chk("mid_rd_done", 32'(rd_done), 32'd0);
    chk("mid_rd_gnt", 32'(rd_gnt), 32'd0);
    sys_nrst = 1'b1;
    log_base = log_q.size();
    auto_drop = 1'b1;
    step(1);
    chk("mid_reissue", 32'(ctl_valid), 32'd1);
    chk("mid_reissue_cmd", 32'(ctl_cmd), 32'd1);
    chk("mid_reissue_addr", 32'(ctl_addr), 32'h123456);
    step(1);
    chk("mid_no_stale_done", 32'(rd_done), 32'd0);
    step(6);
    chk("mid_done_cycle", ev_cyc(find_ev(4, 0)), 5);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
